log_seq: RTL and testbench

- Parametrised sequential integer log2 unit for the calculator datapath. Generalises the 7-bit floor-log2 block.
- Adds: configurable operand width, a start/done handshake, repeated operation without reset, a zero-operand flag, and an optional ceiling mode.
- Sits between the operand register file and the result mux. One operation in flight at a time.

---
 rtl/log_pkg.sv | 17 +
 rtl/log_seq.sv | 140 ++++++++++++++
 tb/tb_log_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/log_pkg.sv
// log_pkg: shared types and helpers for the sequential integer log2 unit.
//   log_state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   log_rw()    : result width for a given operand width, $clog2(width+1)
package log_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } log_state_t;

  // Wide enough to hold any value 0..width, which covers the ceiling result.
  function automatic int log_rw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/log_seq.sv
// log_seq: sequential integer log2 of a WIDTH-bit operand.
// The operand is shifted right one bit per cycle until it drops below 2.
// The number of shifts taken is floor(log2 a).
//
// Build option: LOG_CEIL_EN adds the ceil_mode input. With ceil_mode=1 the
// result is floor plus a sticky bit, set when any 1 was shifted out, which
// gives ceil(log2 a). Without the macro the result is always floor.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active low
//   start     in   request, sampled only in IDLE
//   a         in   operand, captured on the edge that accepts start
//   ceil_mode in   (LOG_CEIL_EN only) ceiling select, captured with start
//   busy      out  operation in progress
//   done      out  one-cycle completion pulse
//   result    out  log2 of the captured operand, held until the next done
//   zero      out  captured operand was 0, held with result
//   dbg_state out  current FSM state
//
// Handshake: start is accepted on an edge when the FSM is in IDLE. busy is
// high from that edge until done rises. done is high for exactly one cycle,
// and result/zero are valid from that cycle on. start is ignored while busy
// or done is high. Requests are not queued.
module log_seq
  import log_pkg::*;
#(
  parameter  int WIDTH = 7,
  localparam int RW    = log_rw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
`ifdef LOG_CEIL_EN
  input  logic             ceil_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    result,
  output logic             zero,
  output log_state_t       dbg_state
);

  log_state_t       state, state_n;
  logic [WIDTH-1:0] buffer, buffer_n;
  logic [RW-1:0]    count, count_n;
  logic             busy_n, done_n, zero_n;
  logic [RW-1:0]    result_n;
`ifdef LOG_CEIL_EN
  logic             sticky, sticky_n;
  logic             ceil_q, ceil_q_n;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      buffer <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
`ifdef LOG_CEIL_EN
      sticky <= 1'b0;
      ceil_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      buffer <= buffer_n;
      count  <= count_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
      zero   <= zero_n;
`ifdef LOG_CEIL_EN
      sticky <= sticky_n;
      ceil_q <= ceil_q_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    buffer_n = buffer;
    count_n  = count;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    zero_n   = zero;
`ifdef LOG_CEIL_EN
    sticky_n = sticky;
    ceil_q_n = ceil_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          buffer_n = a;
          count_n  = '0;
          busy_n   = 1'b1;
          state_n  = SHIFT;
`ifdef LOG_CEIL_EN
          sticky_n = 1'b0;
          ceil_q_n = ceil_mode;
`endif
        end
      end
      SHIFT: begin
        if (buffer >= WIDTH'(2)) begin
          buffer_n = buffer >> 1;
          // count stops at WIDTH-1, so the increment never wraps in RW bits.
          count_n  = count + RW'(1);
`ifdef LOG_CEIL_EN
          sticky_n = sticky | buffer[0];
`endif
        end else begin
`ifdef LOG_CEIL_EN
          // Floor is at most WIDTH-1, so floor+1 still fits RW.
          result_n = count + RW'(ceil_q & sticky);
`else
          result_n = count;
`endif
          zero_n   = (buffer == '0);
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_log_seq.sv
module tb_log_seq;
  import log_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=7 instance
  logic       start7 = 1'b0;
  logic [6:0] a7 = '0;
  logic       busy7, done7, zero7;
  logic [2:0] result7;
  log_state_t st7;

  // WIDTH=16 instance
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic        busy16, done16, zero16;
  logic [4:0]  result16;
  log_state_t  st16;

`ifdef LOG_CEIL_EN
  logic c7 = 1'b0;
  logic c16 = 1'b0;
`endif

  int n_checks = 0;
  int n_err = 0;

  log_seq #(.WIDTH(7)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .a(a7),
`ifdef LOG_CEIL_EN
    .ceil_mode(c7),
`endif
    .busy(busy7), .done(done7), .result(result7), .zero(zero7), .dbg_state(st7)
  );

  log_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16),
`ifdef LOG_CEIL_EN
    .ceil_mode(c16),
`endif
    .busy(busy16), .done(done16), .result(result16), .zero(zero16), .dbg_state(st16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks the cycles after an accepting edge that has just occurred:
  // k shifting cycles with busy=1, then the done cycle, then return to IDLE.
  task automatic expect_op7(input int k, input logic [2:0] res, input logic zr, input string tag);
    chk({tag, " busy_after_accept"}, {30'd0, busy7, done7}, 32'd2);
    for (int i = 0; i < k; i++) begin
      tick();
      chk({tag, " busy_shift"}, {30'd0, busy7, done7}, 32'd2);
    end
    tick();
    chk({tag, " done_pulse"}, {30'd0, busy7, done7}, 32'd1);
    chk({tag, " result"}, {29'd0, result7}, {29'd0, res});
    chk({tag, " zero"}, {31'd0, zero7}, {31'd0, zr});
  endtask

  task automatic run_op7(input logic [6:0] av, input int k, input logic [2:0] res,
                         input logic zr, input string tag);
    start7 = 1'b1;
    a7 = av;
    tick();
    start7 = 1'b0;
    a7 = 7'($urandom_range(0, 127));
    expect_op7(k, res, zr, tag);
    tick();
    chk({tag, " done_drop"}, {30'd0, busy7, done7}, 32'd0);
    chk({tag, " held_result"}, {29'd0, result7}, {29'd0, res});
    chk({tag, " idle"}, 32'(st7), 32'(IDLE));
  endtask

  task automatic run_op16(input logic [15:0] av, input int k, input logic [4:0] res,
                          input logic zr, input string tag);
    start16 = 1'b1;
    a16 = av;
    tick();
    start16 = 1'b0;
    chk({tag, " busy_after_accept"}, {30'd0, busy16, done16}, 32'd2);
    for (int i = 0; i < k; i++) begin
      tick();
      chk({tag, " busy_shift"}, {30'd0, busy16, done16}, 32'd2);
    end
    tick();
    chk({tag, " done_pulse"}, {30'd0, busy16, done16}, 32'd1);
    chk({tag, " result"}, {27'd0, result16}, {27'd0, res});
    chk({tag, " zero"}, {31'd0, zero16}, {31'd0, zr});
    tick();
    chk({tag, " done_drop"}, {30'd0, busy16, done16}, 32'd0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("reset busy/done", {30'd0, busy7, done7}, 32'd0);
    chk("reset result", {29'd0, result7}, 32'd0);
    chk("reset zero", {31'd0, zero7}, 32'd0);
    chk("reset state", 32'(st7), 32'(IDLE));
    rst = 1'b1;
    tick();
    chk("idle no start", {30'd0, busy7, done7}, 32'd0);

    // Floor, WIDTH=7
    run_op7(7'd100, 6, 3'd6, 1'b0, "f100");
    run_op7(7'd127, 6, 3'd6, 1'b0, "f127");
    run_op7(7'd64, 6, 3'd6, 1'b0, "f64");
    run_op7(7'd5, 2, 3'd2, 1'b0, "f5");
    run_op7(7'd3, 1, 3'd1, 1'b0, "f3");
    run_op7(7'd2, 1, 3'd1, 1'b0, "f2");
    run_op7(7'd0, 0, 3'd0, 1'b1, "f0");
    run_op7(7'd1, 0, 3'd0, 1'b0, "f1");
    run_op7(7'd100, 6, 3'd6, 1'b0, "pre_reset");

    // Reset on the 3rd SHIFT edge of a=100
    start7 = 1'b1;
    a7 = 7'd100;
    tick();
    start7 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort busy/done", {30'd0, busy7, done7}, 32'd0);
    chk("abort result", {29'd0, result7}, 32'd0);
    chk("abort zero", {31'd0, zero7}, 32'd0);
    chk("abort state", 32'(st7), 32'(IDLE));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort no done", {30'd0, busy7, done7}, 32'd0);
    end
    run_op7(7'd8, 3, 3'd3, 1'b0, "after_abort8");

    // start held high; a changes while busy and must not be re-sampled
    start7 = 1'b1;
    a7 = 7'd100;
    tick();
    a7 = 7'd5;
    expect_op7(6, 3'd6, 1'b0, "held1");
    tick();
    chk("held DONE ignores start", {30'd0, busy7, done7}, 32'd0);
    tick();
    expect_op7(2, 3'd2, 1'b0, "held2");
    start7 = 1'b0;
    tick();
    chk("held2 done_drop", {30'd0, busy7, done7}, 32'd0);
    tick();
    chk("held no third accept", {30'd0, busy7, done7}, 32'd0);

`ifdef LOG_CEIL_EN
    c7 = 1'b1;
    run_op7(7'd100, 6, 3'd7, 1'b0, "c100");
    run_op7(7'd64, 6, 3'd6, 1'b0, "c64");
    run_op7(7'd127, 6, 3'd7, 1'b0, "c127");
    run_op7(7'd1, 0, 3'd0, 1'b0, "c1");
    run_op7(7'd0, 0, 3'd0, 1'b1, "c0");
    run_op7(7'd5, 2, 3'd3, 1'b0, "c5");
    c7 = 1'b0;
    run_op7(7'd100, 6, 3'd6, 1'b0, "c_off100");
`endif

    // WIDTH=16
    chk("w16 idle", 32'(st16), 32'(IDLE));
    run_op16(16'hFFFF, 15, 5'd15, 1'b0, "w16_fFFFF");
    run_op16(16'h0400, 10, 5'd10, 1'b0, "w16_f400");
`ifdef LOG_CEIL_EN
    c16 = 1'b1;
    run_op16(16'hFFFF, 15, 5'd16, 1'b0, "w16_cFFFF");
    run_op16(16'h0400, 10, 5'd10, 1'b0, "w16_c400");
    c16 = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
